// File: rtl/fpu_issue_buffer.sv
// fpu_issue_buffer: in-order FIFO between decode and the FPU pipeline.
// The head entry drives the FPU instruction port directly. The FPU hazard
// holds the head and suppresses issue. The buffer also provides a flush and
// a saturating count of hazard-stalled cycles.
module fpu_issue_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  input  logic [31:0]                  in_inst,
  output logic                         in_ready,
  input  logic                         flush,
  input  logic                         fpu_hazard,
  output logic [31:0]                  out_inst,
  output logic                         out_legl,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int unsigned INST_W    = 32;
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_OUT_W = $clog2(DEPTH+1);

  logic [INST_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_OUT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0]     stall_q, stall_d;

  logic head_valid;
  logic push;
  logic pop;
  logic stall_hit;

  // Handshake and issue decode. in_ready depends only on registered count.
  // The hazard reaches out_legl combinationally, but never in_ready.
  always_comb begin
    head_valid = (count_q != '0);
    in_ready   = (count_q != CNT_OUT_W'(DEPTH));
    push       = in_valid & in_ready & ~flush;
    out_legl   = head_valid & ~fpu_hazard & ~flush;
    pop        = out_legl;
    stall_hit  = head_valid & fpu_hazard & ~flush;
    out_inst   = head_valid ? mem[rd_ptr_q] : '0;
  end

  // Next-state for pointers, occupancy and the stall counter.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    if (flush) begin
      // A pending push is dropped, so wr_ptr stays where it is.
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_OUT_W'(1);
        2'b01:   count_d = count_q - CNT_OUT_W'(1);
        default: count_d = count_q;
      endcase
    end
    if (stall_hit && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  // Control state register with async reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Entry storage. It has no reset because the occupancy count masks stale data.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_inst;
  end

  // Drive the output ports.
  always_comb begin
    count     = count_q;
    stall_cnt = stall_q;
  end

endmodule

// File: tb/tb_fpu_issue_buffer.sv
// Directed bench for fpu_issue_buffer.
// A vector table covers single issue, hazard stall, full, flush, and push+pop.
// Hand sequences cover stall saturation, a wrapping stream and async reset.
module tb_fpu_issue_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        flush;
  logic        fpu_hazard;
  logic [31:0] out_inst;
  logic        out_legl;
  logic [2:0]  count;
  logic [3:0]  stall_cnt;

  int n_pass = 0;
  int n_total = 0;

  fpu_issue_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_inst    (in_inst),
    .in_ready   (in_ready),
    .flush      (flush),
    .fpu_hazard (fpu_hazard),
    .out_inst   (out_inst),
    .out_legl   (out_legl),
    .count      (count),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        fl;
    logic        hz;
    logic        e_legl;
    logic [31:0] e_inst;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic [3:0]  e_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic fl, input logic hz);
    in_valid   = v;
    in_inst    = d;
    flush      = fl;
    fpu_hazard = hz;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic v, input logic [31:0] d, input logic fl, input logic hz,
                              input logic el, input logic [31:0] ei, input logic [2:0] ec,
                              input logic er, input logic [3:0] es);
    vec_t t;
    t.v = v; t.d = d; t.fl = fl; t.hz = hz;
    t.e_legl = el; t.e_inst = ei; t.e_cnt = ec; t.e_rdy = er; t.e_stall = es;
    vecs.push_back(t);
  endfunction

  initial begin
    int unsigned  nxt;
    int unsigned  issued;
    int unsigned  cyc;
    logic [31:0]  model[$];
    logic [31:0]  exp_w;
    logic         hz;
    logic         do_push;
    logic         exp_legl;

    // Stimulus table. Each row gives the inputs for one cycle and the outputs expected before the next edge.
    //   v     data           fl    hz    legl  inst           cnt   rdy   stall
    // Single issue, one-cycle latency
    add(1'b1, 32'h0020F053, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 4'd0);
    add(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0020F053, 3'd1, 1'b1, 4'd0);
    add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 4'd0);
    // Three hazard cycles, then issue
    add(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 4'd0);
    add(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h12345678, 3'd1, 1'b1, 4'd0);
    add(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h12345678, 3'd1, 1'b1, 4'd1);
    add(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h12345678, 3'd1, 1'b1, 4'd2);
    add(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678, 3'd1, 1'b1, 4'd3);
    add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 4'd3);
    // Fill under hazard; the 5th word is refused until the buffer drains
    add(1'b1, 32'hA0000000, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 1'b1, 4'd3);
    add(1'b1, 32'hA0000001, 1'b0, 1'b1, 1'b0, 32'hA0000000, 3'd1, 1'b1, 4'd3);
    add(1'b1, 32'hA0000002, 1'b0, 1'b1, 1'b0, 32'hA0000000, 3'd2, 1'b1, 4'd4);
    add(1'b1, 32'hA0000003, 1'b0, 1'b1, 1'b0, 32'hA0000000, 3'd3, 1'b1, 4'd5);
    add(1'b1, 32'hA0000004, 1'b0, 1'b1, 1'b0, 32'hA0000000, 3'd4, 1'b0, 4'd6);
    add(1'b1, 32'hA0000004, 1'b0, 1'b1, 1'b0, 32'hA0000000, 3'd4, 1'b0, 4'd7);
    add(1'b1, 32'hA0000004, 1'b0, 1'b0, 1'b1, 32'hA0000000, 3'd4, 1'b0, 4'd8);
    add(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA0000001, 3'd3, 1'b1, 4'd8);
    add(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA0000002, 3'd2, 1'b1, 4'd8);
    add(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA0000003, 3'd1, 1'b1, 4'd8);
    add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 4'd8);
    // count=3, then push together with flush: the pushed word never issues
    add(1'b1, 32'hB0000000, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 1'b1, 4'd8);
    add(1'b1, 32'hB0000001, 1'b0, 1'b1, 1'b0, 32'hB0000000, 3'd1, 1'b1, 4'd8);
    add(1'b1, 32'hB0000002, 1'b0, 1'b1, 1'b0, 32'hB0000000, 3'd2, 1'b1, 4'd9);
    add(1'b1, 32'hB0000003, 1'b1, 1'b0, 1'b0, 32'hB0000000, 3'd3, 1'b1, 4'd10);
    add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 4'd10);
    // Push and pop in the same cycle at count=1
    add(1'b1, 32'hC0000000, 1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 4'd10);
    add(1'b1, 32'hC0000001, 1'b0, 1'b0, 1'b1, 32'hC0000000, 3'd1, 1'b1, 4'd10);
    add(1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hC0000001, 3'd1, 1'b1, 4'd10);
    add(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 4'd10);

    // Check the reset state.
    rstn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    check("reset count", 32'(count), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_legl", 32'(out_legl), 32'd0);
    check("reset out_inst", out_inst, 32'h0);
    check("reset stall_cnt", 32'(stall_cnt), 32'd0);
    #4 rstn = 1'b1;
    tick();

    // Apply the vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].fl, vecs[i].hz);
      #2;
      check($sformatf("v%0d out_legl", i), 32'(out_legl), 32'(vecs[i].e_legl));
      check($sformatf("v%0d out_inst", i), out_inst, vecs[i].e_inst);
      check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_stall));
      tick();
    end

    // Hold a hazard against one head: the stall counter saturates at 15.
    drive(1'b1, 32'hD0000000, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    #2;
    check("stall saturate", 32'(stall_cnt), 32'd15);
    check("stall hold inst", out_inst, 32'hD0000000);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    check("post-sat issue", 32'(out_legl), 32'd1);
    tick();

    // Stream 10 words with random hazards and compare against a queue model.
    nxt = 0;
    issued = 0;
    cyc = 0;
    while ((issued < 10) && (cyc < 300)) begin
      hz = ($urandom_range(0, 2) == 0);
      do_push = (nxt < 10);
      drive(do_push, 32'hE0000000 + 32'(nxt), 1'b0, hz);
      #2;
      check($sformatf("stream c%0d count", cyc), 32'(count), 32'(model.size()));
      exp_legl = (model.size() != 0) && !hz;
      check($sformatf("stream c%0d out_legl", cyc), 32'(out_legl), 32'(exp_legl));
      if (exp_legl) begin
        exp_w = model.pop_front();
        check($sformatf("stream issue %0d", issued), out_inst, exp_w);
        issued++;
      end
      if (do_push && (model.size() + (exp_legl ? 1 : 0) < DEPTH)) begin
        model.push_back(32'hE0000000 + 32'(nxt));
        nxt++;
      end
      tick();
      cyc++;
    end
    check("stream all issued", 32'(issued), 32'd10);

    // Assert reset asynchronously in mid-cycle with two entries held.
    drive(1'b1, 32'hF0000000, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'hF0000001, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("pre-reset count", 32'(count), 32'd2);
    #1 rstn = 1'b0;
    #1;
    check("async out_legl", 32'(out_legl), 32'd0);
    check("async count", 32'(count), 32'd0);
    check("async stall_cnt", 32'(stall_cnt), 32'd0);
    check("async in_ready", 32'(in_ready), 32'd1);
    check("async out_inst", out_inst, 32'h0);
    #3 rstn = 1'b1;
    tick();
    #2;
    check("after reset count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
